// File: rtl/data_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_responder_pkg
//   Shared definitions for the MEM-stage data memory responder.
//   - Default data/address widths, shared with the CPU datapath.
//   - Legal maximum for the programmable access latency and the width of
//     the wait counter derived from it.
//   - Responder FSM state type.
// ---------------------------------------------------------------------------
package data_mem_responder_pkg;

  // Datapath defaults, kept in step with the CPU pipeline.
  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_ADDR_W = 4;

  // Largest supported number of extra wait cycles per access.
  localparam int WAIT_CYCLES_MAX = 15;

  // Wide enough to hold WAIT_CYCLES_MAX - 1 down to 0.
  localparam int WAIT_CNT_W = $clog2(WAIT_CYCLES_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

endpackage : data_mem_responder_pkg

// File: rtl/data_mem_responder_dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
//   2**ADDR_W x DATA_W register array.
//   Synchronous write, combinational read, asynchronous clear to zero.
//
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low clear of every word
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     raddr  in   read address
//     rdata  out  word at raddr (value before any write on the coming edge)
// ---------------------------------------------------------------------------
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : dmem_array

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for MEM-stage loads and stores. One request is
//   accepted in IDLE, held for WAIT_CYCLES extra cycles, committed on the
//   edge that enters RESP, and presented until the initiator takes it.
//
//   Ports:
//     clk            in   rising-edge clock
//     reset          in   asynchronous active-low reset
//     req_valid      in   request present
//     req_write      in   1 = store, 0 = load
//     req_addr       in   word address
//     req_wdata      in   store data
//     req_ready      out  responder is idle and will accept a request
//     rsp_valid      out  response present
//     rsp_ready      in   initiator takes the response
//     rsp_rdata      out  load data or echoed store data
//     rsp_was_write  out  response belongs to a store
//     stall          out  ~req_ready, holds the pipeline
//     rd_count       out  completed loads, wrapping
//     wr_count       out  completed stores, wrapping
// ---------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_was_write,
  output logic              stall,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_CYCLES_MAX) begin : g_bad_wait
    $error("data_mem_responder: WAIT_CYCLES out of range 0..15");
  end

  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_e state_q, state_d;

  logic [WAIT_CNT_W-1:0] wcnt_q, wcnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  was_write_q, was_write_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;

  logic                  commit;
  logic                  commit_write;
  logic [ADDR_W-1:0]     commit_addr;
  logic [DATA_W-1:0]     commit_wdata;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_rdata;

  // FSM, wait counter and request capture
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (NO_WAIT) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          wcnt_d = wcnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait the commit happens on the accept edge itself, so the live
  // request fields feed the commit; otherwise the captured copies do.
  assign commit_write = (state_q == ST_IDLE) ? req_write : wr_q;
  assign commit_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign commit_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign mem_we       = commit & commit_write;

  // Response data and access counters update only at the commit edge; the
  // load path reads the array before the same-edge write lands.
  always_comb begin
    rdata_d     = rdata_q;
    was_write_d = was_write_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    if (commit) begin
      was_write_d = commit_write;
      if (commit_write) begin
        rdata_d  = commit_wdata;
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end else begin
        rdata_d  = mem_rdata;
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      was_write_q <= 1'b0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      was_write_q <= was_write_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (reset),
    .we    (mem_we),
    .waddr (commit_addr),
    .wdata (commit_wdata),
    .raddr (commit_addr),
    .rdata (mem_rdata)
  );

  assign req_ready     = (state_q == ST_IDLE);
  assign stall         = (state_q != ST_IDLE);
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_was_write = was_write_q;
  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int WAIT_A = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A: default latency
  logic        a_req_valid, a_req_write, a_req_ready;
  logic [3:0]  a_req_addr;
  logic [15:0] a_req_wdata;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_was_write, a_stall;
  logic [15:0] a_rsp_rdata;
  logic [7:0]  a_rd_count, a_wr_count;

  // Instance B: zero extra wait
  logic        b_req_valid, b_req_write, b_req_ready;
  logic [3:0]  b_req_addr;
  logic [15:0] b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_was_write, b_stall;
  logic [15:0] b_rsp_rdata;
  logic [7:0]  b_rd_count, b_wr_count;

  data_mem_responder #(.DATA_W(16), .ADDR_W(4), .WAIT_CYCLES(WAIT_A), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_write(a_req_write), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_ready(a_req_ready),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_was_write(a_rsp_was_write), .stall(a_stall),
    .rd_count(a_rd_count), .wr_count(a_wr_count)
  );

  data_mem_responder #(.DATA_W(16), .ADDR_W(4), .WAIT_CYCLES(0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_write(b_req_write), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_ready(b_req_ready),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_was_write(b_rsp_was_write), .stall(b_stall),
    .rd_count(b_rd_count), .wr_count(b_wr_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model for instance A: memory contents and completed-access counts
  logic [15:0] ref_mem [16];
  int          ref_rd;
  int          ref_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
    ref_rd = 0;
    ref_wr = 0;
  endtask

  task automatic check_a_reset_values(input string tag);
    check({tag, "_req_ready"}, a_req_ready, 1);
    check({tag, "_stall"}, a_stall, 0);
    check({tag, "_rsp_valid"}, a_rsp_valid, 0);
    check({tag, "_rsp_rdata"}, a_rsp_rdata, 0);
    check({tag, "_was_write"}, a_rsp_was_write, 0);
    check({tag, "_rd_count"}, a_rd_count, 0);
    check({tag, "_wr_count"}, a_wr_count, 0);
  endtask

  // One complete transaction on instance A. Called and returns at a negedge.
  // hold = number of edges rsp_ready stays low while the response is shown.
  task automatic access(input bit wr, input logic [3:0] a, input logic [15:0] d, input int hold);
    logic [15:0] exp_data;
    int n;
    check("idle_ready", a_req_ready, 1);
    check("idle_stall", a_stall, 0);
    a_req_valid = 1'b1;
    a_req_write = wr;
    a_req_addr  = a;
    a_req_wdata = d;
    a_rsp_ready = (hold == 0);
    if (wr) begin
      ref_mem[a] = d;
      exp_data   = d;
      ref_wr     = (ref_wr + 1) % 256;
    end else begin
      exp_data = ref_mem[a];
      ref_rd   = (ref_rd + 1) % 256;
    end
    @(posedge clk);
    @(negedge clk);
    check("busy_ready", a_req_ready, 0);
    check("busy_stall", a_stall, 1);
    n = 0;
    // Scramble the request lines while busy; none of it may be sampled.
    while (!a_rsp_valid && n < 20) begin
      a_req_valid = 1'($urandom_range(0, 1));
      a_req_write = 1'($urandom_range(0, 1));
      a_req_addr  = 4'($urandom);
      a_req_wdata = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("latency", n, WAIT_A);
    check("rsp_rdata", a_rsp_rdata, exp_data);
    check("rsp_was_write", a_rsp_was_write, wr);
    check("rd_count", a_rd_count, ref_rd);
    check("wr_count", a_wr_count, ref_wr);
    for (int h = 0; h < hold; h++) begin
      a_req_valid = ~a_req_valid;
      a_req_addr  = 4'd7;
      a_req_write = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check("hold_rsp_valid", a_rsp_valid, 1);
      check("hold_stall", a_stall, 1);
      check("hold_rd_count", a_rd_count, ref_rd);
      check("hold_wr_count", a_wr_count, ref_wr);
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rsp_drop", a_rsp_valid, 0);
    check("post_ready", a_req_ready, 1);
    check("held_rdata", a_rsp_rdata, exp_data);
    check("held_was_write", a_rsp_was_write, wr);
    a_rsp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset       = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_a_reset_values("rst");
    check("rst_b_req_ready", b_req_ready, 1);
    check("rst_b_rsp_valid", b_rsp_valid, 0);
    reset = 1'b1;
    @(negedge clk);

    // Directed store/load sequence
    access(1'b1, 4'd3, 16'hBEEF, 0);
    access(1'b0, 4'd3, 16'h0000, 0);
    access(1'b0, 4'd4, 16'h0000, 0);

    // Zero-wait instance: response right after the accept edge
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 4'd15; b_req_wdata = 16'h1234;
    b_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b_st_rsp_valid", b_rsp_valid, 1);
    check("b_st_ready", b_req_ready, 0);
    check("b_st_rdata", b_rsp_rdata, 16'h1234);
    check("b_st_was_write", b_rsp_was_write, 1);
    check("b_st_wr_count", b_wr_count, 1);
    b_req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b_st_drop", b_rsp_valid, 0);
    check("b_idle_ready", b_req_ready, 1);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 4'd15; b_req_wdata = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    check("b_ld_rsp_valid", b_rsp_valid, 1);
    check("b_ld_rdata", b_rsp_rdata, 16'h1234);
    check("b_ld_was_write", b_rsp_was_write, 0);
    check("b_ld_rd_count", b_rd_count, 1);
    b_req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b_ld_drop", b_rsp_valid, 0);

    // Response back-pressure with req lines toggling on addr 7
    access(1'b1, 4'd9, 16'h5A5A, 5);
    access(1'b0, 4'd7, 16'h0000, 5);

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      access(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a store's wait phase
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 4'd5; a_req_wdata = 16'hAAAA;
    a_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_busy", a_req_ready, 0);
    a_req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_a_reset_values("mid_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access(1'b0, 4'd5, 16'h0000, 0);
    check("mid_rst_wr_count", a_wr_count, 0);

    // Counter wrap: 257 back-to-back loads from a clean reset
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 257; i++) begin
      access(1'b0, 4'($urandom), 16'h0000, 0);
    end
    check("wrap_rd_count", a_rd_count, 1);
    check("wrap_wr_count", a_wr_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_data_mem_responder
